// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, R-type func codes, controller state and instruction classes
// shared by the 16-bit CPU control unit.
`default_nettype none

package cpu_pkg;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_J    = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_NOT = 4'b0110;
  localparam logic [3:0] FN_XOR = 4'b0111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_t;

  localparam logic [2:0] CLS_R    = 3'd0;
  localparam logic [2:0] CLS_ADDI = 3'd1;
  localparam logic [2:0] CLS_LW   = 3'd2;
  localparam logic [2:0] CLS_SW   = 3'd3;
  localparam logic [2:0] CLS_BEQ  = 3'd4;
  localparam logic [2:0] CLS_J    = 3'd5;
  localparam logic [2:0] CLS_HALT = 3'd6;
  localparam logic [2:0] CLS_ILL  = 3'd7;

  function automatic logic func_legal(input logic [3:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_NOT) || (f == FN_XOR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational IR decode into instruction class, legality,
// ALU control pair, immediate and write-register select.
`default_nettype none

module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic        legal,
  output logic [2:0]  cls,
  output logic [2:0]  alu_opcode,
  output logic [3:0]  alu_func,
  output logic [15:0] imm,
  output logic [2:0]  reg_wsel
);

  always_comb begin
    legal      = 1'b1;
    cls        = CLS_ILL;
    alu_opcode = 3'b000;
    alu_func   = 4'b0000;
    case (ir[15:13])
      OP_R: begin
        cls      = CLS_R;
        legal    = func_legal(ir[3:0]);
        alu_func = ir[3:0];
      end
      OP_ADDI: begin cls = CLS_ADDI; alu_opcode = 3'b001; end
      OP_LW:   begin cls = CLS_LW;   alu_opcode = 3'b001; end
      OP_SW:   begin cls = CLS_SW;   alu_opcode = 3'b001; end
      // The ALU control only understands 000/001, so beq borrows R-type sub.
      OP_BEQ:  begin cls = CLS_BEQ;  alu_func = FN_SUB; end
      OP_J:    cls = CLS_J;
      OP_HALT: cls = CLS_HALT;
      default: legal = 1'b0;
    endcase
  end

  assign imm      = (ir[15:13] == OP_J) ? {3'b000, ir[12:0]} : {{9{ir[6]}}, ir[6:0]};
  assign reg_wsel = (ir[15:13] == OP_R) ? ir[6:4] : ir[9:7];

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle FETCH/DECODE/EXEC/MEM/WB controller holding the IR.
// Strobes are registered and pulse for the cycle following the edge that commits them.
`default_nettype none

module cpu_ctrl_fsm
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic        imem_req,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        alu_zero,
  output logic [2:0]  alu_opcode,
  output logic [3:0]  alu_func,
  output logic        alu_src_imm,
  output logic [2:0]  ir_opcode,
  output logic [2:0]  rs,
  output logic [2:0]  rt,
  output logic [2:0]  rd,
  output logic [15:0] imm,
  output logic        reg_we,
  output logic [2:0]  reg_wsel,
  output logic        wb_from_mem,
  output logic        pc_inc,
  output logic        pc_branch,
  output logic        pc_jump,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state
);

  state_t      st;
  logic [15:0] ir;
  logic        legal;
  logic [2:0]  cls;

  ctrl_decode u_dec (
    .ir         (ir),
    .legal      (legal),
    .cls        (cls),
    .alu_opcode (alu_opcode),
    .alu_func   (alu_func),
    .imm        (imm),
    .reg_wsel   (reg_wsel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= FETCH;
      ir        <= '0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      reg_we    <= 1'b0;
      pc_inc    <= 1'b0;
      pc_branch <= 1'b0;
      pc_jump   <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      pc_inc    <= 1'b0;
      pc_branch <= 1'b0;
      pc_jump   <= 1'b0;
      case (st)
        FETCH: begin
          if (imem_req && imem_valid) begin
            ir       <= imem_rdata;
            pc_inc   <= 1'b1;
            imem_req <= 1'b0;
            st       <= DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        DECODE: begin
          if (!legal || cls == CLS_HALT) begin
            illegal <= !legal;
            halted  <= 1'b1;
            st      <= HALT;
          end else if (cls == CLS_J) begin
            pc_jump  <= 1'b1;
            imem_req <= 1'b1;
            st       <= FETCH;
          end else begin
            st <= EXEC;
          end
        end
        EXEC: begin
          case (cls)
            CLS_R, CLS_ADDI: st <= WB;
            CLS_LW, CLS_SW: begin
              dmem_req <= 1'b1;
              st       <= MEM;
            end
            default: begin
              pc_branch <= (cls == CLS_BEQ) && alu_zero;
              imem_req  <= 1'b1;
              st        <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (cls == CLS_LW) begin
              st <= WB;
            end else begin
              imem_req <= 1'b1;
              st       <= FETCH;
            end
          end
        end
        WB: begin
          reg_we   <= 1'b1;
          imem_req <= 1'b1;
          st       <= FETCH;
        end
        HALT: st <= HALT;
        default: begin
          imem_req <= 1'b1;
          st       <= FETCH;
        end
      endcase
    end
  end

  assign state       = st;
  assign ir_opcode   = ir[15:13];
  assign rs          = ir[12:10];
  assign rt          = ir[9:7];
  assign rd          = ir[6:4];
  assign dmem_we     = dmem_req && (cls == CLS_SW);
  assign wb_from_mem = (cls == CLS_LW);
  assign alu_src_imm = ((cls == CLS_ADDI) || (cls == CLS_LW) || (cls == CLS_SW)) &&
                       ((st == EXEC) || (st == MEM) || (st == WB));

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed vectors with hand-computed expectations for cpu_ctrl_fsm.
`default_nettype none

module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        imem_req;
  logic        dmem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic        alu_zero;
  logic [2:0]  alu_opcode;
  logic [3:0]  alu_func;
  logic        alu_src_imm;
  logic [2:0]  ir_opcode, rs, rt, rd;
  logic [15:0] imm;
  logic        reg_we;
  logic [2:0]  reg_wsel;
  logic        wb_from_mem;
  logic        pc_inc, pc_branch, pc_jump;
  logic        halted, illegal;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  cpu_ctrl_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .imem_req    (imem_req),
    .dmem_ready  (dmem_ready),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .alu_zero    (alu_zero),
    .alu_opcode  (alu_opcode),
    .alu_func    (alu_func),
    .alu_src_imm (alu_src_imm),
    .ir_opcode   (ir_opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .reg_we      (reg_we),
    .reg_wsel    (reg_wsel),
    .wb_from_mem (wb_from_mem),
    .pc_inc      (pc_inc),
    .pc_branch   (pc_branch),
    .pc_jump     (pc_jump),
    .halted      (halted),
    .illegal     (illegal),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from a FETCH cycle with imem_req high until FETCH is
  // re-entered. Strobe positions are counted in edges from the start (edge 1 = IR load).
  task automatic run(input logic [15:0] word, input int fw, input int dw, input logic z,
                     output int cyc, output int inc_at, output int jmp_at, output int br_n,
                     output int we_at, output int we_n, output int dreq_n, output int dwe_n,
                     output int imm_n, output int wfm_we, output int clash);
    int dcnt;
    cyc = 0; inc_at = 0; jmp_at = 0; br_n = 0; we_at = 0; we_n = 0;
    dreq_n = 0; dwe_n = 0; imm_n = 0; wfm_we = 0; clash = 0; dcnt = 0;
    alu_zero = z;
    for (int k = 0; k < 60; k++) begin
      imem_valid = (k == fw);
      imem_rdata = word;
      dmem_ready = dmem_req && (dcnt == dw);
      if (dmem_req) dcnt++;
      step;
      cyc++;
      imem_valid = 1'b0;
      dmem_ready = 1'b0;
      if (pc_inc) inc_at = cyc;
      if (pc_jump) jmp_at = cyc;
      if (pc_branch) br_n++;
      if (reg_we) begin we_at = cyc; we_n++; wfm_we = int'(wb_from_mem); end
      if (dmem_req) dreq_n++;
      if (dmem_we) dwe_n++;
      if (alu_src_imm) imm_n++;
      if (pc_inc && (pc_branch || pc_jump)) clash++;
      if (state == 3'd0 && cyc > fw + 1) break;
    end
  endtask

  initial begin
    int cyc, inc_at, jmp_at, br_n, we_at, we_n, dreq_n, dwe_n, imm_n, wfm_we, clash;
    int act;

    rst_n = 1'b0; imem_rdata = '0; imem_valid = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0;
    step; step;
    chk("rst_state", state, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_strobes", {reg_we, pc_inc, pc_branch, pc_jump}, 0);
    rst_n = 1'b1;
    step;
    chk("rel_imem_req", imem_req, 1);

    // R-type sub, rd=3
    run(16'h0231, 0, 0, 1'b0, cyc, inc_at, jmp_at, br_n, we_at, we_n, dreq_n, dwe_n, imm_n, wfm_we, clash);
    chk("r_cycles", cyc, 4);
    chk("r_inc_at", inc_at, 1);
    chk("r_we_at", we_at, 4);
    chk("r_we_n", we_n, 1);
    chk("r_imm_n", imm_n, 0);
    chk("r_alu", {alu_opcode, alu_func}, {3'b000, 4'b0001});
    chk("r_fields", {ir_opcode, rs, rt, rd, reg_wsel}, {3'd0, 3'd0, 3'd4, 3'd3, 3'd3});
    chk("r_wfm", wb_from_mem, 0);

    // lw with three dmem wait cycles
    run(16'h4A05, 0, 3, 1'b0, cyc, inc_at, jmp_at, br_n, we_at, we_n, dreq_n, dwe_n, imm_n, wfm_we, clash);
    chk("lw_cycles", cyc, 8);
    chk("lw_dreq_n", dreq_n, 4);
    chk("lw_dwe_n", dwe_n, 0);
    chk("lw_we_at", we_at, 8);
    chk("lw_wfm_we", wfm_we, 1);
    chk("lw_imm_n", imm_n, 6);
    chk("lw_alu", {alu_opcode, alu_func}, {3'b001, 4'b0000});
    chk("lw_wsel_imm", {reg_wsel, imm}, {3'd4, 16'h0005});

    // addi with two instruction-fetch wait cycles
    run(16'h2285, 2, 0, 1'b0, cyc, inc_at, jmp_at, br_n, we_at, we_n, dreq_n, dwe_n, imm_n, wfm_we, clash);
    chk("addi_cycles", cyc, 6);
    chk("addi_inc_at", inc_at, 3);
    chk("addi_we_at", we_at, 6);
    chk("addi_imm_n", imm_n, 2);
    chk("addi_wsel_imm", {reg_wsel, imm}, {3'd5, 16'h0005});

    // beq taken then not taken
    run(16'h807F, 0, 0, 1'b1, cyc, inc_at, jmp_at, br_n, we_at, we_n, dreq_n, dwe_n, imm_n, wfm_we, clash);
    chk("beq1_cycles", cyc, 3);
    chk("beq1_br_n", br_n, 1);
    chk("beq1_clash", clash, 0);
    chk("beq1_imm", imm, 16'hFFFF);
    chk("beq1_alu", {alu_opcode, alu_func}, {3'b000, 4'b0001});
    run(16'h807F, 0, 0, 1'b0, cyc, inc_at, jmp_at, br_n, we_at, we_n, dreq_n, dwe_n, imm_n, wfm_we, clash);
    chk("beq0_cycles", cyc, 3);
    chk("beq0_br_n", br_n, 0);
    chk("beq0_we_n", we_n, 0);

    // jump
    run(16'hA123, 0, 0, 1'b0, cyc, inc_at, jmp_at, br_n, we_at, we_n, dreq_n, dwe_n, imm_n, wfm_we, clash);
    chk("j_cycles", cyc, 2);
    chk("j_jmp_at", jmp_at, 2);
    chk("j_we_n", we_n, 0);
    chk("j_clash", clash, 0);
    chk("j_imm", imm, 16'h0123);

    // sw, zero wait
    run(16'h6000, 0, 0, 1'b0, cyc, inc_at, jmp_at, br_n, we_at, we_n, dreq_n, dwe_n, imm_n, wfm_we, clash);
    chk("sw_cycles", cyc, 4);
    chk("sw_dreq_n", dreq_n, 1);
    chk("sw_dwe_n", dwe_n, 1);
    chk("sw_we_n", we_n, 0);

    // illegal R-type func halts the machine
    imem_valid = 1'b1; imem_rdata = 16'h0008;
    step;
    imem_valid = 1'b0;
    step;
    chk("ill_state", state, 7);
    chk("ill_flags", {halted, illegal}, 2'b11);
    chk("ill_imem_req", imem_req, 0);
    act = 0;
    imem_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      if (imem_req || pc_inc || reg_we || dmem_req || pc_jump || pc_branch) act++;
    end
    imem_valid = 1'b0;
    chk("halt_quiet", act, 0);
    chk("halt_stays", {state, halted, illegal}, {3'd7, 2'b11});

    // reset clears sticky status
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    chk("rst2_status", {imem_req, halted, illegal, state}, {1'b1, 1'b0, 1'b0, 3'd0});

    // reset in the middle of a sw memory access
    imem_valid = 1'b1; imem_rdata = 16'h6000;
    step;
    imem_valid = 1'b0;
    step; step;
    chk("mid_dmem", {dmem_req, dmem_we, state}, {1'b1, 1'b1, 3'd3});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async", {dmem_req, dmem_we, state, reg_we}, {1'b0, 1'b0, 3'd0, 1'b0});
    act = 0;
    for (int k = 0; k < 2; k++) begin
      step;
      if (reg_we || imem_req || dmem_req) act++;
    end
    chk("mid_held", act, 0);
    rst_n = 1'b1;
    step;
    chk("mid_release", {imem_req, halted, state}, {1'b1, 1'b0, 3'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
